rom_fetch_arbiter: RTL and testbench
====================================

Name: rom_fetch_arbiter

Overview:
- Shares a single 16-bit ROM read port (SDRAM) between the main 68K program ROM window (0x000000-0x07FFFF) and the sound 68K program ROM window (0x000000-0x01FFFF).
- Arbitrates round-robin between the two requesters.
- Holds a one-word last-fetch cache per requester.
- Generates each CPU's DTACK_n for ROM cycles.
- Sits between the chip-select decode outputs (rom selects) and the SDRAM controller read channel.

Parameters:
- SDR_AW, 24: SDRAM byte-address width.
- SND_BASE, 24'h080000: SDRAM byte offset of the sound ROM image; main ROM is based at 0.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous assertion, active low
- flush  in  1  invalidate both caches (ROM download / core reset)
- mp_cs  in  1  main CPU ROM select
- mp_as_n  in  1  main CPU address strobe
- mp_a  in  18  main CPU word address (byte A18:A1)
- mp_dout  out  16  ROM word to main CPU
- mp_dtack_n  out  1  main CPU DTACK for ROM cycles
- ms_cs  in  1  sound CPU ROM select
- ms_as_n  in  1  sound CPU address strobe
- ms_a  in  16  sound CPU word address (byte A16:A1)
- ms_dout  out  16  ROM word to sound CPU
- ms_dtack_n  out  1  sound CPU DTACK for ROM cycles
- sdr_req  out  1  one-cycle read request pulse
- sdr_addr  out  SDR_AW  byte address, valid when sdr_req=1
- sdr_ack  in  1  one-cycle read-data-valid strobe
- sdr_data  in  16  read data, valid with sdr_ack

Behaviour:
- Reset values (async, reset_n=0):
  - mp_dtack_n=1, ms_dtack_n=1, sdr_req=0, sdr_addr=0, mp_dout=0, ms_dout=0.
  - FSM=IDLE, both caches invalid, rr_last=sound (main wins first tie).
- Active cycle, per requester: cs=1 and as_n=0 and not yet served. served sets on DTACK assertion and clears when as_n=1.
- Cache: per requester tag (word address), data, valid.
  - Hit (valid and tag==address) in an active cycle: dout<=data, dtack_n<=0 on the next clock. Latency is 1 cycle; no SDRAM access.
  - A hit is serviced regardless of FSM state, concurrently with the other requester's fetch.
- Address map:
  - main: sdr_addr = {mp_a,1'b0}, zero-extended.
  - sound: sdr_addr = SND_BASE + {ms_a,1'b0}.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: for requesters with an active miss, grant the sole one. If both miss, grant the one not equal to rr_last. Latch the grant id and address, then go to ISSUE.
  - ISSUE: sdr_req=1 for exactly one cycle with the latched address, then go to WAIT.
  - WAIT: on sdr_ack, write sdr_data to the granted cache (tag=latched address, valid=1) and set rr_last=grant. Go to IDLE.
    - If the granted requester is still in the same active cycle (as_n still 0, same address), drive dout=sdr_data and dtack_n=0 in the same registered update.
- DTACK hold: dtack_n stays 0 until as_n=1. It is then 1 from the following clock. dout is held while dtack_n=0.
- Withdrawal: if as_n rises during ISSUE or WAIT, the fetch still completes and fills the cache, but no DTACK is given.
- Stray acks: sdr_ack in IDLE or ISSUE is ignored.
- Flush:
  - Clears both valid bits.
  - If flush and an sdr_ack fill occur in the same cycle, flush wins (entry stays invalid); DTACK is still given for that fetch.
  - Flush does not abort an in-flight fetch.
- Width rules: address compare is on full requester word widths. SND_BASE addition wraps modulo 2^SDR_AW.
- Mid-operation reset: all state returns to reset values. An ack arriving after release is ignored per the stray-ack rule.
- Throughput: at most one outstanding SDRAM request.
- Worst-case miss latency per requester is one other fetch plus its own fetch.

Decomposition:
- Shared package (rom_arb_pkg): FSM state enum {IDLE,ISSUE,WAIT}; requester id constants REQ_MAIN=0, REQ_SND=1.
- One natural sub-module: rom_word_cache (tag/data/valid, hit compare, fill, flush), instantiated twice with width parameter 18 and 16.

Test Plan:
- Main miss at byte 0x000100, sdr_ack 5 cycles after sdr_req:
  - sdr_addr=0x000100, one sdr_req pulse.
  - mp_dout=sdr_data (0x4E71) with mp_dtack_n=0 on the ack+1 edge.
  - Repeat the same address: dtack 1 cycle after as_n falls, no sdr_req.
- Simultaneous misses (main 0x000200, sound 0x000010) from reset:
  - main issued first (sdr_addr=0x000200), then sound (sdr_addr=0x080010).
  - Next simultaneous pair issues sound first.
- Sound hit during main WAIT: ms_dtack_n=0 one cycle after ms_as_n falls, while the main fetch continues undisturbed.
- Main as_n rises during WAIT: no mp_dtack_n assertion. Re-access of the same address later hits (no sdr_req).
- flush pulse coincident with sdr_ack: DTACK delivered for the current cycle; the next access to the same address issues a new sdr_req.
- reset_n low during WAIT, ack arriving 2 cycles after release:
  - all outputs at reset values immediately.
  - the late ack produces no DTACK and no cache fill; the next access misses.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared types for the ROM fetch arbiter: FSM states and requester ids.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    localparam logic REQ_MAIN = 1'b0;
    localparam logic REQ_SND  = 1'b1;

    localparam int MP_AW = 18;
    localparam int MS_AW = 16;

endpackage

// File: rtl/rom_word_cache.sv
// One-word last-fetch cache: tag/data/valid with hit compare, fill and flush.
module rom_word_cache #(
    parameter int AW = 18
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_flush,
    input  logic          i_fill,
    input  logic [AW-1:0] i_fill_tag,
    input  logic [15:0]   i_fill_data,
    input  logic [AW-1:0] i_addr,
    output logic          o_hit,
    output logic [15:0]   o_data
);

    logic [AW-1:0] r_tag;
    logic [15:0]   r_data;
    logic          r_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tag   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (i_fill) begin
                r_tag  <= i_fill_tag;
                r_data <= i_fill_data;
            end
            // a flush landing on the fill cycle leaves the entry invalid
            if (i_flush)
                r_valid <= 1'b0;
            else if (i_fill)
                r_valid <= 1'b1;
        end
    end

    assign o_hit  = r_valid && (r_tag == i_addr);
    assign o_data = r_data;

endmodule

// File: rtl/rom_fetch_arbiter.sv
// Shares one SDRAM read port between the main and sound 68K program ROMs,
// round-robin arbitrated, with a one-word cache and DTACK per CPU.
module rom_fetch_arbiter
    import rom_arb_pkg::*;
#(
    parameter int                SDR_AW   = 24,
    parameter logic [SDR_AW-1:0] SND_BASE = 24'h080000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              mp_cs,
    input  logic              mp_as_n,
    input  logic [17:0]       mp_a,
    output logic [15:0]       mp_dout,
    output logic              mp_dtack_n,
    input  logic              ms_cs,
    input  logic              ms_as_n,
    input  logic [15:0]       ms_a,
    output logic [15:0]       ms_dout,
    output logic              ms_dtack_n,
    output logic              sdr_req,
    output logic [SDR_AW-1:0] sdr_addr,
    input  logic              sdr_ack,
    input  logic [15:0]       sdr_data
);

    arb_state_e        r_state;
    arb_state_e        w_next;
    logic              r_gnt;
    logic              r_rr_last;
    logic              r_gone;
    logic [MP_AW-1:0]  r_tag;
    logic [SDR_AW-1:0] r_addr;

    logic              r_mp_served;
    logic              r_ms_served;
    logic              r_mp_dtack_n;
    logic              r_ms_dtack_n;
    logic [15:0]       r_mp_dout;
    logic [15:0]       r_ms_dout;

    logic              w_mp_act;
    logic              w_ms_act;
    logic              w_mp_hit;
    logic              w_ms_hit;
    logic [15:0]       w_mp_cdata;
    logic [15:0]       w_ms_cdata;
    logic              w_mp_miss;
    logic              w_ms_miss;
    logic              w_ack;
    logic              w_mp_fill;
    logic              w_ms_fill;
    logic              w_mp_done;
    logic              w_ms_done;
    logic              w_grant;
    logic              w_gnt_id;
    logic              w_sdr_req;
    logic              w_gnt_as_n;
    logic [SDR_AW-1:0] w_mp_sdr;
    logic [SDR_AW-1:0] w_ms_sdr;

    assign w_mp_act  = mp_cs && !mp_as_n && !r_mp_served;
    assign w_ms_act  = ms_cs && !ms_as_n && !r_ms_served;
    assign w_mp_miss = w_mp_act && !w_mp_hit;
    assign w_ms_miss = w_ms_act && !w_ms_hit;

    assign w_mp_sdr = SDR_AW'({mp_a, 1'b0});
    assign w_ms_sdr = SND_BASE + SDR_AW'({ms_a, 1'b0});

    assign w_ack     = (r_state == WAIT) && sdr_ack;
    assign w_mp_fill = w_ack && (r_gnt == REQ_MAIN);
    assign w_ms_fill = w_ack && (r_gnt == REQ_SND);

    // data goes straight to the CPU only if its original bus cycle survived
    assign w_mp_done = w_mp_fill && !r_gone && w_mp_act
                       && (mp_a == r_tag);
    assign w_ms_done = w_ms_fill && !r_gone && w_ms_act
                       && (ms_a == r_tag[MS_AW-1:0]);

    assign w_gnt_as_n = (r_gnt == REQ_MAIN) ? mp_as_n : ms_as_n;

    rom_word_cache #(.AW(MP_AW)) u_mp_cache (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_flush     (flush),
        .i_fill      (w_mp_fill),
        .i_fill_tag  (r_tag),
        .i_fill_data (sdr_data),
        .i_addr      (mp_a),
        .o_hit       (w_mp_hit),
        .o_data      (w_mp_cdata)
    );

    rom_word_cache #(.AW(MS_AW)) u_ms_cache (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_flush     (flush),
        .i_fill      (w_ms_fill),
        .i_fill_tag  (r_tag[MS_AW-1:0]),
        .i_fill_data (sdr_data),
        .i_addr      (ms_a),
        .o_hit       (w_ms_hit),
        .o_data      (w_ms_cdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_grant   = 1'b0;
        w_gnt_id  = REQ_MAIN;
        w_sdr_req = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_mp_miss || w_ms_miss) begin
                    w_grant = 1'b1;
                    w_next  = ISSUE;
                    if (w_mp_miss && w_ms_miss)
                        w_gnt_id = ~r_rr_last;
                    else if (w_ms_miss)
                        w_gnt_id = REQ_SND;
                end
            end
            ISSUE: begin
                w_sdr_req = 1'b1;
                w_next    = WAIT;
            end
            WAIT: begin
                if (sdr_ack)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_gnt     <= REQ_MAIN;
            r_rr_last <= REQ_SND;
            r_gone    <= 1'b0;
            r_tag     <= '0;
            r_addr    <= '0;
        end else begin
            if (w_grant) begin
                r_gnt  <= w_gnt_id;
                r_gone <= 1'b0;
                if (w_gnt_id == REQ_SND) begin
                    r_tag  <= {2'b00, ms_a};
                    r_addr <= w_ms_sdr;
                end else begin
                    r_tag  <= mp_a;
                    r_addr <= w_mp_sdr;
                end
            end else if (r_state != IDLE && w_gnt_as_n) begin
                r_gone <= 1'b1;
            end
            if (w_ack)
                r_rr_last <= r_gnt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mp_served  <= 1'b0;
            r_mp_dtack_n <= 1'b1;
            r_mp_dout    <= '0;
        end else if (mp_as_n) begin
            r_mp_served  <= 1'b0;
            r_mp_dtack_n <= 1'b1;
        end else if (w_mp_done) begin
            r_mp_served  <= 1'b1;
            r_mp_dtack_n <= 1'b0;
            r_mp_dout    <= sdr_data;
        end else if (w_mp_act && w_mp_hit) begin
            r_mp_served  <= 1'b1;
            r_mp_dtack_n <= 1'b0;
            r_mp_dout    <= w_mp_cdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ms_served  <= 1'b0;
            r_ms_dtack_n <= 1'b1;
            r_ms_dout    <= '0;
        end else if (ms_as_n) begin
            r_ms_served  <= 1'b0;
            r_ms_dtack_n <= 1'b1;
        end else if (w_ms_done) begin
            r_ms_served  <= 1'b1;
            r_ms_dtack_n <= 1'b0;
            r_ms_dout    <= sdr_data;
        end else if (w_ms_act && w_ms_hit) begin
            r_ms_served  <= 1'b1;
            r_ms_dtack_n <= 1'b0;
            r_ms_dout    <= w_ms_cdata;
        end
    end

    assign sdr_req    = w_sdr_req;
    assign sdr_addr   = r_addr;
    assign mp_dout    = r_mp_dout;
    assign mp_dtack_n = r_mp_dtack_n;
    assign ms_dout    = r_ms_dout;
    assign ms_dtack_n = r_ms_dtack_n;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Scoreboard bench for rom_fetch_arbiter: SDRAM/ROM model, directed and random CPU traffic.
module tb_rom_fetch_arbiter;

    localparam logic [23:0] SNDB = 24'h080000;

    logic        clk = 1'b0;
    logic        reset_n, flush;
    logic        mp_cs, mp_as_n, ms_cs, ms_as_n;
    logic [17:0] mp_a;
    logic [15:0] ms_a;
    logic [15:0] mp_dout, ms_dout, sdr_data;
    logic        mp_dtack_n, ms_dtack_n, sdr_req, sdr_ack;
    logic [23:0] sdr_addr;

    int tests = 0;
    int fails = 0;
    int ack_delay = 5;
    bit rand_delay = 0;
    bit flush_on_ack = 0;
    int req_cnt = 0;
    int m_last;
    logic [23:0] req_log[$];
    logic [15:0] exp_mp[$];
    logic [15:0] exp_ms[$];
    logic [15:0] rom[int];

    rom_fetch_arbiter dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .mp_cs(mp_cs), .mp_as_n(mp_as_n), .mp_a(mp_a),
        .mp_dout(mp_dout), .mp_dtack_n(mp_dtack_n),
        .ms_cs(ms_cs), .ms_as_n(ms_as_n), .ms_a(ms_a),
        .ms_dout(ms_dout), .ms_dtack_n(ms_dtack_n),
        .sdr_req(sdr_req), .sdr_addr(sdr_addr),
        .sdr_ack(sdr_ack), .sdr_data(sdr_data)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_rd(input logic [23:0] a);
        if (!rom.exists(int'(a)))
            rom[int'(a)] = 16'($urandom);
        return rom[int'(a)];
    endfunction

    function automatic logic [23:0] mp_byte(input logic [17:0] w);
        return 24'(32'(w) * 2);
    endfunction

    function automatic logic [23:0] ms_byte(input logic [15:0] w);
        return 24'((32'(SNDB) + 32'(w) * 2) % 32'h1000000);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mp_go(input logic [17:0] a, input bit expect_ack);
        mp_cs = 1'b1; mp_as_n = 1'b0; mp_a = a;
        if (expect_ack) exp_mp.push_back(rom_rd(mp_byte(a)));
    endtask

    task automatic ms_go(input logic [15:0] a, input bit expect_ack);
        ms_cs = 1'b1; ms_as_n = 1'b0; ms_a = a;
        if (expect_ack) exp_ms.push_back(rom_rd(ms_byte(a)));
    endtask

    task automatic mp_stop;
        mp_cs = 1'b0; mp_as_n = 1'b1;
    endtask

    task automatic ms_stop;
        ms_cs = 1'b0; ms_as_n = 1'b1;
    endtask

    task automatic wait_mp(output int n);
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (mp_dtack_n !== 1'b0 && n < 200);
    endtask

    task automatic wait_ms(output int n);
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (ms_dtack_n !== 1'b0 && n < 200);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_mp_dtack"}, 32'(mp_dtack_n), 1);
        chk({nm, "_ms_dtack"}, 32'(ms_dtack_n), 1);
        chk({nm, "_sdr_req"}, 32'(sdr_req), 0);
        chk({nm, "_sdr_addr"}, 32'(sdr_addr), 0);
        chk({nm, "_mp_dout"}, 32'(mp_dout), 0);
        chk({nm, "_ms_dout"}, 32'(ms_dout), 0);
    endtask

    // Both CPUs miss together; round robin picks the one not served last.
    task automatic do_pair(input logic [17:0] wa, input logic [15:0] sa);
        int n1, n2, base;
        bit snd_first;
        base = req_log.size();
        snd_first = (m_last == 0);
        mp_go(wa, 1); ms_go(sa, 1);
        fork
            wait_mp(n1);
            wait_ms(n2);
        join
        chk("pair_req0", 32'(req_log[base]), snd_first ? 32'(ms_byte(sa)) : 32'(mp_byte(wa)));
        chk("pair_req1", 32'(req_log[base+1]), snd_first ? 32'(mp_byte(wa)) : 32'(ms_byte(sa)));
        chk("pair_lat_mp", 32'(n1), snd_first ? 32'(2*ack_delay+4) : 32'(ack_delay+2));
        chk("pair_lat_ms", 32'(n2), snd_first ? 32'(ack_delay+2) : 32'(2*ack_delay+4));
        m_last = snd_first ? 0 : 1;
        mp_stop; ms_stop; tick(2);
    endtask

    // SDRAM model: one request at a time, data from the ROM image.
    initial begin
        int d;
        logic [23:0] cur;
        bit fl;
        sdr_ack = 1'b0; sdr_data = '0;
        forever begin
            @(negedge clk);
            if (sdr_req === 1'b1) begin
                req_cnt++;
                req_log.push_back(sdr_addr);
                cur = sdr_addr;
                d = rand_delay ? int'($urandom_range(1, 6)) : ack_delay;
                @(negedge clk);
                chk("req_pulse", 32'(sdr_req), 0);
                repeat (d - 1) @(negedge clk);
                sdr_data = rom_rd(cur);
                sdr_ack = 1'b1;
                fl = flush_on_ack;
                if (fl) flush = 1'b1;
                @(negedge clk);
                sdr_ack = 1'b0;
                if (fl) flush = 1'b0;
            end
        end
    end

    // Monitor: every DTACK assertion pops one expected word.
    initial begin
        logic pm, ps;
        logic [15:0] em, es;
        pm = 1'b1; ps = 1'b1; em = '0; es = '0;
        forever begin
            @(negedge clk);
            if (pm === 1'b1 && mp_dtack_n === 1'b0) begin
                if (exp_mp.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL mp_dtack: unexpected dtack, dout %h, none required", mp_dout);
                end else begin
                    em = exp_mp.pop_front();
                    chk("mp_dout", 32'(mp_dout), 32'(em));
                end
            end else if (pm === 1'b0 && mp_dtack_n === 1'b0) begin
                chk("mp_hold", 32'(mp_dout), 32'(em));
            end
            if (ps === 1'b1 && ms_dtack_n === 1'b0) begin
                if (exp_ms.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL ms_dtack: unexpected dtack, dout %h, none required", ms_dout);
                end else begin
                    es = exp_ms.pop_front();
                    chk("ms_dout", 32'(ms_dout), 32'(es));
                end
            end else if (ps === 1'b0 && ms_dtack_n === 1'b0) begin
                chk("ms_hold", 32'(ms_dout), 32'(es));
            end
            pm = mp_dtack_n;
            ps = ms_dtack_n;
        end
    end

    initial begin
        int n, n2, c0, lows;
        logic [17:0] mpool[4];
        logic [15:0] spool[4];
        mpool[0] = 18'h00000; mpool[1] = 18'h00001;
        mpool[2] = 18'h3FFFF; mpool[3] = 18'h00100;
        spool[0] = 16'h0000;  spool[1] = 16'hFFFF;
        spool[2] = 16'h0001;  spool[3] = 16'h0008;
        rom[32'h000100] = 16'h4E71;
        reset_n = 1'b0; flush = 1'b0;
        mp_cs = 1'b0; mp_as_n = 1'b1; mp_a = '0;
        ms_cs = 1'b0; ms_as_n = 1'b1; ms_a = '0;
        tick(1);
        chk_reset("rst");
        tick(2);
        reset_n = 1'b1;
        tick(2);

        // lone main miss, then same address hits
        ack_delay = 5;
        c0 = req_cnt;
        mp_go(18'h00080, 1);
        wait_mp(n);
        chk("miss_lat", 32'(n), 7);
        chk("miss_reqs", 32'(req_cnt - c0), 1);
        chk("miss_addr", 32'(req_log[req_log.size()-1]), 32'h000100);
        chk("miss_data", 32'(mp_dout), 32'h4E71);
        mp_stop; tick(1);
        chk("dtack_release", 32'(mp_dtack_n), 1);
        tick(1);
        mp_go(18'h00080, 1);
        wait_mp(n);
        chk("hit_lat", 32'(n), 1);
        chk("hit_noreq", 32'(req_cnt - c0), 1);
        mp_stop; tick(2);

        // simultaneous misses from reset, alternation afterwards
        reset_n = 1'b0; tick(2); reset_n = 1'b1; tick(1);
        m_last = 1;
        do_pair(18'h00100, 16'h0008);
        mp_go(18'h00200, 1);
        wait_mp(n);
        m_last = 0;
        mp_stop; tick(2);
        do_pair(18'h00180, 16'h0010);

        // sound hit while main fetch waits on SDRAM
        ack_delay = 6;
        c0 = req_cnt;
        mp_go(18'h00300, 1);
        fork
            wait_mp(n);
            begin
                tick(3);
                ms_go(16'h0010, 1);
                wait_ms(n2);
            end
        join
        chk("conc_ms_lat", 32'(n2), 1);
        chk("conc_mp_lat", 32'(n), 8);
        chk("conc_reqs", 32'(req_cnt - c0), 1);
        mp_stop; ms_stop; tick(2);

        // main withdraws during WAIT: fill but no dtack
        ack_delay = 4;
        c0 = req_cnt;
        mp_go(18'h00500, 0);
        tick(3);
        mp_stop;
        lows = 0;
        repeat (10) begin
            @(negedge clk);
            if (mp_dtack_n === 1'b0) lows++;
        end
        chk("wd_nodtack", 32'(lows), 0);
        mp_go(18'h00500, 1);
        wait_mp(n);
        chk("wd_hit_lat", 32'(n), 1);
        chk("wd_reqs", 32'(req_cnt - c0), 1);
        mp_stop; tick(2);

        // flush coincident with the fill
        ack_delay = 3;
        flush_on_ack = 1;
        mp_go(18'h00600, 1);
        wait_mp(n);
        chk("fl_lat", 32'(n), 5);
        flush_on_ack = 0;
        mp_stop; tick(2);
        c0 = req_cnt;
        mp_go(18'h00600, 1);
        wait_mp(n);
        chk("fl_refetch_lat", 32'(n), 5);
        chk("fl_refetch_req", 32'(req_cnt - c0), 1);
        mp_stop; tick(2);

        // reset during WAIT, ack arrives after release
        ack_delay = 10;
        c0 = req_cnt;
        mp_go(18'h00700, 0);
        tick(5);
        reset_n = 1'b0;
        mp_stop;
        #1;
        chk_reset("midrst");
        tick(4);
        reset_n = 1'b1;
        lows = 0;
        repeat (6) begin
            @(negedge clk);
            if (mp_dtack_n === 1'b0) lows++;
        end
        chk("rst_late_ack", 32'(lows), 0);
        chk("rst_reqs", 32'(req_cnt - c0), 1);
        ack_delay = 5;
        mp_go(18'h00700, 1);
        wait_mp(n);
        chk("rst_miss_lat", 32'(n), 7);
        chk("rst_miss_req", 32'(req_cnt - c0), 2);
        mp_stop; tick(2);

        // random traffic from both CPUs with random flushes
        rand_delay = 1;
        fork
            repeat (40) begin
                int w;
                tick($urandom_range(0, 3));
                mp_go(mpool[$urandom_range(0, 3)], 1);
                wait_mp(w);
                chk("rnd_mp_bound", 32'(w <= 16), 1);
                tick($urandom_range(0, 2));
                mp_stop; tick(1);
            end
            repeat (40) begin
                int w;
                tick($urandom_range(0, 3));
                ms_go(spool[$urandom_range(0, 3)], 1);
                wait_ms(w);
                chk("rnd_ms_bound", 32'(w <= 16), 1);
                tick($urandom_range(0, 2));
                ms_stop; tick(1);
            end
            repeat (30) begin
                tick($urandom_range(3, 15));
                flush = 1'b1;
                tick(1);
                flush = 1'b0;
            end
        join
        tick(20);
        chk("mp_queue_empty", 32'(exp_mp.size()), 0);
        chk("ms_queue_empty", 32'(exp_ms.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
